// File: rtl/fast_square_integrate_if.sv
// Sample stream from the fast-square combiner plus the result drain port.
// master: the side that produces samples and drains results.
// slave: the integrator.
interface fast_square_integrate_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32
) ();
    logic                        data_in_strobe;
    logic signed [IN_WIDTH-1:0]  i_in;
    logic signed [IN_WIDTH-1:0]  q_in;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] i_out;
    logic signed [ACC_WIDTH-1:0] q_out;
    logic [7:0]                  out_tag;

    modport master (
        output data_in_strobe, i_in, q_in, out_ready,
        input  out_valid, i_out, q_out, out_tag
    );

    modport slave (
        input  data_in_strobe, i_in, q_in, out_ready,
        output out_valid, i_out, q_out, out_tag
    );
endinterface

// File: rtl/fast_square_integrate.sv
// Integrate-and-dump of combiner I/Q over 2^log2_n samples per frequency step,
// with a settling window after each step and a FWFT result FIFO.
//
//   state  | meaning
//   IDLE   | disabled; nothing accumulated
//   SETTLE | discarding samples after a frequency step
//   ACCUM  | summing samples, dumping a word every N strobes
module fast_square_integrate #(
    parameter int IN_WIDTH       = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int MAX_LOG2_N     = 16,
    parameter int SETTLE_SAMPLES = 2,
    parameter int LOG2_DEPTH     = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [4:0]            log2_n_i,
    input  logic                  freq_step_i,
    fast_square_integrate_if.slave bus,
    output logic [LOG2_DEPTH:0]   fifo_level_o,
    output logic                  overflow_o
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CNT_W = MAX_LOG2_N + 1;
    localparam int SET_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    state_t                      state_q, state_d;
    logic [SET_W-1:0]            settle_q, settle_d, settle_inc;
    logic [CNT_W-1:0]            remain_q, n_m1_q, n_m1_new;
    logic [4:0]                  log2_eff;
    logic signed [ACC_WIDTH-1:0] acc_i_q, acc_q_q, samp_i, samp_q, sum_i, sum_q;
    logic [7:0]                  freq_idx_q;
    logic                        enter_accum, take_sample, dump;

    logic [ACC_WIDTH-1:0]        mem_i [DEPTH];
    logic [ACC_WIDTH-1:0]        mem_q [DEPTH];
    logic [7:0]                  mem_t [DEPTH];
    logic [LOG2_DEPTH:0]         wr_q, rd_q, rd_next, level, level_after_pop, pop_ext;
    logic                        full, pop, push_ok;
    logic [ACC_WIDTH-1:0]        head_i_q, head_q_q;
    logic [7:0]                  head_t_q;

    assign log2_eff   = (log2_n_i > 5'(MAX_LOG2_N)) ? 5'(MAX_LOG2_N) : log2_n_i;
    assign n_m1_new   = (CNT_W'(1) << log2_eff) - CNT_W'(1);
    assign samp_i     = {{(ACC_WIDTH-IN_WIDTH){bus.i_in[IN_WIDTH-1]}}, bus.i_in};
    assign samp_q     = {{(ACC_WIDTH-IN_WIDTH){bus.q_in[IN_WIDTH-1]}}, bus.q_in};
    assign sum_i      = acc_i_q + samp_i;
    assign sum_q      = acc_q_q + samp_q;
    assign settle_inc = settle_q + SET_W'(1);
    assign dump       = take_sample && (remain_q == '0);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next state; disable beats a frequency step, which beats any strobe
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        enter_accum = 1'b0;
        take_sample = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else if (freq_step_i && state_q != IDLE) begin
            state_d  = SETTLE;
            settle_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
                SETTLE: begin
                    if (SETTLE_SAMPLES == 0) begin
                        state_d     = ACCUM;
                        enter_accum = 1'b1;
                    end else if (bus.data_in_strobe) begin
                        settle_d = settle_inc;
                        if (settle_inc == SET_W'(SETTLE_SAMPLES)) begin
                            state_d     = ACCUM;
                            enter_accum = 1'b1;
                        end
                    end
                end
                ACCUM: take_sample = bus.data_in_strobe;
                default: state_d = IDLE;
            endcase
        end
    end

    // Accumulators and remaining-sample down-counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            remain_q <= '0;
            n_m1_q   <= '0;
        end else if (enter_accum) begin
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            remain_q <= n_m1_new;
            n_m1_q   <= n_m1_new;
        end else if (dump) begin
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            remain_q <= n_m1_q;
        end else if (take_sample) begin
            acc_i_q  <= sum_i;
            acc_q_q  <= sum_q;
            remain_q <= remain_q - CNT_W'(1);
        end else if (state_d != ACCUM) begin
            acc_i_q  <= '0;
            acc_q_q  <= '0;
        end
    end

    // Frequency index counts every step, even while idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) freq_idx_q <= '0;
        else if (freq_step_i) freq_idx_q <= freq_idx_q + 8'd1;
    end

    // A frequency step always restarts accumulation, so the current index
    // is the index of the word's first sample.
    assign level           = wr_q - rd_q;
    assign full            = (level == (LOG2_DEPTH+1)'(DEPTH));
    assign pop             = bus.out_valid && bus.out_ready;
    assign pop_ext         = {{LOG2_DEPTH{1'b0}}, pop};
    assign rd_next         = rd_q + pop_ext;
    assign level_after_pop = level - pop_ext;
    assign push_ok         = dump && (!full || pop);

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_i[wr_q[LOG2_DEPTH-1:0]] <= sum_i;
            mem_q[wr_q[LOG2_DEPTH-1:0]] <= sum_q;
            mem_t[wr_q[LOG2_DEPTH-1:0]] <= freq_idx_q;
        end
    end

    // Pointers, sticky overflow, and a registered head that holds when empty
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_o <= 1'b0;
            head_i_q   <= '0;
            head_q_q   <= '0;
            head_t_q   <= '0;
        end else begin
            rd_q <= rd_next;
            if (push_ok) wr_q <= wr_q + (LOG2_DEPTH+1)'(1);
            if (dump && full && !pop) overflow_o <= 1'b1;
            if (level_after_pop != '0) begin
                head_i_q <= mem_i[rd_next[LOG2_DEPTH-1:0]];
                head_q_q <= mem_q[rd_next[LOG2_DEPTH-1:0]];
                head_t_q <= mem_t[rd_next[LOG2_DEPTH-1:0]];
            end else if (push_ok) begin
                head_i_q <= sum_i;
                head_q_q <= sum_q;
                head_t_q <= freq_idx_q;
            end
        end
    end

    assign bus.out_valid = (level != '0);
    assign bus.i_out     = head_i_q;
    assign bus.q_out     = head_q_q;
    assign bus.out_tag   = head_t_q;
    assign fifo_level_o  = level;
endmodule

// File: doc/fast_square_integrate.md
Name: fast_square_integrate

Overview:
- Downstream stage of the fast-square baseband combiner; consumes its strobed 16-bit I/Q output and integrate-and-dumps it over 2^log2_n samples per frequency step.
- Discards a programmable settling window after each frequency step.
- Queues per-step I/Q sums, tagged with the frequency index, in a small first-word-fall-through (FWFT) FIFO.
- A valid/ready interface drains the FIFO to the RX packer.

Parameters:
- IN_WIDTH, 16: width of signed i_in/q_in.
- ACC_WIDTH, 32: width of signed accumulators and i_out/q_out; must be >= IN_WIDTH+MAX_LOG2_N.
- MAX_LOG2_N, 16: maximum integration exponent; larger log2_n values are clamped to this.
- SETTLE_SAMPLES, 2: strobed samples discarded after each freq_step.
- LOG2_DEPTH, 3: result FIFO depth = 2^LOG2_DEPTH (default 8).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high = run; low = return to IDLE.
- log2_n  in  5  integration length exponent, N = 2^log2_n.
- data_in_strobe  in  1  i_in/q_in valid this cycle.
- i_in  in  IN_WIDTH  signed I sample from the combiner.
- q_in  in  IN_WIDTH  signed Q sample from the combiner.
- freq_step  in  1  one-cycle pulse: the combiner has moved to the next frequency.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word this cycle.
- i_out  out  ACC_WIDTH  head-of-FIFO I sum.
- q_out  out  ACC_WIDTH  head-of-FIFO Q sum.
- out_tag  out  8  frequency index of the head word.
- fifo_level  out  LOG2_DEPTH+1  number of occupied FIFO entries.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM enters IDLE.
  - Accumulators, sample counter, settle counter, freq index, FIFO pointers and overflow all clear to 0.
  - Outputs: out_valid=0, fifo_level=0, i_out=q_out=0, out_tag=0, overflow=0.
  - Deassertion takes effect at the next clock edge.
- FSM states: IDLE, SETTLE, ACCUM.
  - IDLE: waits for enable=1, then enters SETTLE with settle count 0.
  - SETTLE: each strobe discards the sample and increments the settle count. On the strobe that brings the count to SETTLE_SAMPLES, enter ACCUM. SETTLE_SAMPLES=0 enters ACCUM on the next cycle.
  - ACCUM: on entry, latch N = 2^min(log2_n, MAX_LOG2_N) and clear the accumulators and counter. Each strobe adds sign-extended i_in/q_in.
  - Dump: on the strobe that is the Nth sample, push the sum including that sample, then restart accumulation with the accumulators at 0. The FIFO entry is visible (out_valid) on the cycle after that strobe edge. The FSM stays in ACCUM.
  - Latched N changes only on re-entry to ACCUM.
- freq_step, in any state except IDLE:
  - Increments freq index mod 256.
  - Discards any partial sum; enters SETTLE with settle count 0.
  - Takes priority over a coincident strobe, which is discarded and not counted.
- freq_step in IDLE: freq index still increments.
- enable=0 (any state):
  - Next state is IDLE; partial sum discarded.
  - FIFO contents are retained and remain drainable.
- Arithmetic:
  - Full-precision signed accumulation; no saturation is needed given the ACC_WIDTH rule.
  - Outputs are two's complement.
- FIFO:
  - FWFT: i_out/q_out/out_tag reflect the head entry whenever out_valid=1.
  - Pop occurs when out_valid && out_ready.
  - While out_valid && !out_ready, the outputs stay stable.
  - Push when full with no pop in that cycle: result dropped, overflow set to 1, cleared only by reset.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push and pop in the same cycle when empty: the word is accepted and appears on the next cycle.
  - When empty, the outputs hold their last value.
- Tag: the pushed word carries the freq index current when its first sample was accumulated.

Test Plan:
- Constant input, log2_n=2, enable=1, strobe every cycle, i_in=0x1000, q_in=0x0100; freq_step pulse, then 6 strobes -> after 2 discarded and 4 accumulated: out_valid=1, i_out=0x00004000, q_out=0x00000400, out_tag=1.
- Alternating q_in 0x0000/0x0100 each strobe, i_in=0, log2_n=3 -> every 8 strobes a word with i_out=0, q_out=0x00000400; consecutive words identical.
- Negative input: i_in=0xFFFF, q_in=0x8000, log2_n=2 -> i_out=0xFFFFFFFC, q_out=0xFFFE0000.
- Backpressure: out_ready=0, log2_n=0, 10 post-settle strobes -> fifo_level=8, overflow=1. Then out_ready=1 -> 8 words drained in push order; overflow stays 1.
- freq_step after 3 of 4 samples (log2_n=2) -> no word pushed, out_tag of the next word increments by 1. Coincident strobe+freq_step -> sample not counted.
- Assert reset low mid-ACCUM with 3 words queued -> immediately out_valid=0, fifo_level=0, overflow=0. Release and restart -> the first word equals a clean-start result.
